pattern_player: RTL and testbench
=================================

PATTERN_PLAYER -- requirements
Module: pattern_player

Interface
REQ-001 Parameter HOLD, 4, clock cycles each symbol is presented (min 1).
REQ-002 Parameter GAP, 2, blank cycles between symbols when the gap feature is compiled in (min 1).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request playback of A/B; sampled in IDLE only.
REQ-006 abort  input  1  cancel playback; sampled in every state.
REQ-007 A  input  64  first pattern word; nibble 15 (A[63:60]) plays first.
REQ-008 B  input  64  second pattern word; plays after A.
REQ-009 len  input  6  number of symbols to play; valid 1..32.
REQ-010 sym  output  4  current symbol nibble.
REQ-011 sym_valid  output  1  sym is being presented.
REQ-012 sym_idx  output  5  index of presented symbol, 0-based.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the last symbol completes.

Function
REQ-015 States: IDLE, SHOW, GAP, DONE; all outputs registered.
REQ-016 IDLE + start=1 + abort=0 + len!=0: capture {A,B} into a 128-bit shift register and min(len,32) into a count register; next state SHOW.
REQ-017 IDLE + start=1 + len=0: ignored; stay IDLE, no done.
REQ-018 len>32: clamped to 32.
REQ-019 Latency: start sampled at cycle 0 -> sym_valid=1 from cycle 1.
REQ-020 Order: A[63:60], A[59:56] .. A[3:0], then B[63:60] .. B[3:0]; shift register moves left by 4 per symbol.
REQ-021 SHOW: sym_valid=1, sym/sym_idx constant for exactly HOLD cycles (hold counter).
REQ-022 SHOW end, symbols remaining: to GAP (gap feature in) or directly to SHOW with next symbol (gap feature out); sym_idx increments by 1.
REQ-023 SHOW end, last symbol: to DONE; no gap after the last symbol.
REQ-024 GAP: sym_valid=0, sym=0, sym_idx holds; exactly GAP cycles, then SHOW.
REQ-025 DONE: done=1, sym_valid=0, sym=0, busy=1 for one cycle; next state IDLE.
REQ-026 A, B, len changes after capture do not affect playback.
REQ-027 start while busy: ignored, no restart.
REQ-028 abort=1 in any state: next state IDLE, sym_valid=0, sym=0, sym_idx=0, no done pulse.
REQ-029 abort and start both high in IDLE: abort wins; no capture.
REQ-030 IDLE outputs: sym=0, sym_valid=0, sym_idx=0, busy=0, done=0.

Reset
REQ-031 rst=1 at a clock edge: state IDLE; sym=0, sym_valid=0, sym_idx=0, busy=0, done=0; hold/gap counters, count and shift registers cleared.
REQ-032 rst overrides start and abort, including mid-playback; no done pulse is produced.

Configuration
REQ-033 Macro PATTERN_PLAYER_GAP_EN defined: GAP state present; GAP blank cycles between consecutive symbols.
REQ-034 Macro PATTERN_PLAYER_GAP_EN undefined: GAP state and counter absent; symbols play back-to-back; GAP parameter has no effect.

Verification (HOLD=4, GAP=2, start at cycle 0)
REQ-035 Gap out, A=64'h0123_4567_89AB_CDEF, len=3 -> sym 0 cycles 1-4, 1 cycles 5-8, 2 cycles 9-12; done cycle 13; busy low cycle 14.
REQ-036 Gap in, same stimulus -> sym 0 cycles 1-4, blank 5-6, sym 1 7-10, blank 11-12, sym 2 13-16, done cycle 17.
REQ-037 Gap out, len=32, B=64'hFEDC_BA98_7654_3210 -> sym_idx 16 shows F at cycles 65-68; sym_idx 31 shows 0; done cycle 129.
REQ-038 len=0 -> busy stays 0, no done; len=40 -> 32 symbols played, identical to len=32.
REQ-039 Gap out, len=3, abort at cycle 6 -> cycle 7 IDLE, sym_valid=0, busy=0, no done; new start plays from sym_idx 0.
REQ-040 rst at cycle 5 mid-SHOW -> cycle 6 all outputs 0; start=1 at cycle 5 with rst=1 is not captured.

Source files
------------

// File: rtl/pattern_player.sv
// Plays up to 32 nibbles from {A,B}, MSB first, each held HOLD cycles.
// Define PATTERN_PLAYER_GAP_EN to insert GAP blank cycles between symbols.
//
// state  | meaning
// IDLE   | waiting for start, outputs zero
// SHOW   | presenting current symbol for HOLD cycles
// GAP    | blank cycles between symbols (gap build only)
// DONE   | one-cycle done pulse, then back to IDLE
module pattern_player #(
  parameter int HOLD = 4,
  parameter int GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [5:0]  len,
  output logic [3:0]  sym,
  output logic        sym_valid,
  output logic [4:0]  sym_idx,
  output logic        busy,
  output logic        done
);

  if (HOLD < 1 || GAP < 1) begin : g_param_check
    $error("pattern_player: HOLD and GAP must be >= 1");
  end

  localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

`ifdef PATTERN_PLAYER_GAP_EN
  localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP, S_DONE} state_t;

  logic [GW-1:0] gap_q, gap_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_DONE} state_t;
`endif

  state_t         state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [127:0]   shreg_q, shreg_d;
  logic [3:0]     sym_d;
  logic           valid_d;
  logic [4:0]     idx_d;
  logic           busy_d;
  logic           done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      sym       <= '0;
      sym_valid <= 1'b0;
      sym_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PATTERN_PLAYER_GAP_EN
      gap_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      sym       <= sym_d;
      sym_valid <= valid_d;
      sym_idx   <= idx_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef PATTERN_PLAYER_GAP_EN
      gap_q     <= gap_d;
`endif
    end
  end

  // cnt_q holds the number of symbols still to play after the current one
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sym_d   = sym;
    valid_d = sym_valid;
    idx_d   = sym_idx;
    busy_d  = busy;
    done_d  = 1'b0;
`ifdef PATTERN_PLAYER_GAP_EN
    gap_d   = gap_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
      sym_d   = '0;
      valid_d = 1'b0;
      idx_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sym_d   = '0;
          valid_d = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b0;
          if (start && len != 6'd0) begin
            shreg_d = {A, B};
            cnt_d   = (len > 6'd32) ? 5'd31 : 5'(len - 6'd1);
            hold_d  = HOLD_LAST;
            state_d = S_SHOW;
            sym_d   = shreg_d[127:124];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
        S_SHOW: begin
          if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
          end else if (cnt_q == 5'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            sym_d   = '0;
            valid_d = 1'b0;
          end else begin
            shreg_d = shreg_q << 4;
            cnt_d   = cnt_q - 5'd1;
`ifdef PATTERN_PLAYER_GAP_EN
            state_d = S_GAP;
            gap_d   = GAP_LAST;
            sym_d   = '0;
            valid_d = 1'b0;
`else
            hold_d  = HOLD_LAST;
            sym_d   = shreg_d[127:124];
            idx_d   = sym_idx + 5'd1;
`endif
          end
        end
`ifdef PATTERN_PLAYER_GAP_EN
        S_GAP: begin
          if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
          end else begin
            state_d = S_SHOW;
            hold_d  = HOLD_LAST;
            sym_d   = shreg_q[127:124];
            valid_d = 1'b1;
            idx_d   = sym_idx + 5'd1;
          end
        end
`endif
        S_DONE: begin
          state_d = S_IDLE;
          sym_d   = '0;
          valid_d = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          sym_d   = '0;
          valid_d = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_player.sv
// Bench for pattern_player: directed scenarios plus random playbacks checked
// cycle by cycle against an expected-output timeline built from {A,B} and len.
module tb_pattern_player;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
`ifdef PATTERN_PLAYER_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [63:0] A, B;
  logic [5:0]  len;
  logic [3:0]  sym;
  logic        sym_valid;
  logic [4:0]  sym_idx;
  logic        busy, done;

  typedef struct packed {
    logic [3:0] sym;
    logic       v;
    logic [4:0] idx;
    logic       busy;
    logic       done;
    logic       idx_known;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  pattern_player #(.HOLD(HOLD), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .A(A), .B(B), .len(len),
    .sym(sym), .sym_valid(sym_valid), .sym_idx(sym_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic exp_t idle_e();
    exp_t e;
    e = '{sym: 4'h0, v: 1'b0, idx: 5'd0, busy: 1'b0, done: 1'b0, idx_known: 1'b1};
    return e;
  endfunction

  // Timeline for cycles 1.. after start: each symbol HOLD cycles, optional
  // blanks between symbols, one done cycle, then one idle cycle.
  task automatic build(input logic [63:0] a, input logic [63:0] b, input int l);
    logic [127:0] w;
    int n;
    exp_t e;
    w = {a, b};
    n = (l > 32) ? 32 : l;
    q.delete();
    for (int k = 0; k < n; k++) begin
      for (int h = 0; h < HOLD; h++) begin
        e = '{sym: 4'((w >> (124 - 4 * k)) & 128'hF), v: 1'b1, idx: 5'(k),
              busy: 1'b1, done: 1'b0, idx_known: 1'b1};
        q.push_back(e);
      end
      if (GAP_ON && k < n - 1) begin
        for (int g = 0; g < GAP; g++) begin
          e = '{sym: 4'h0, v: 1'b0, idx: 5'(k), busy: 1'b1, done: 1'b0, idx_known: 1'b1};
          q.push_back(e);
        end
      end
    end
    e = '{sym: 4'h0, v: 1'b0, idx: 5'd0, busy: 1'b1, done: 1'b1, idx_known: 1'b0};
    q.push_back(e);
    q.push_back(idle_e());
  endtask

  task automatic check_cycle(input string ctx, input exp_t e);
    chk({ctx, " sym"}, 32'(sym), 32'(e.sym));
    chk({ctx, " sym_valid"}, 32'(sym_valid), 32'(e.v));
    chk({ctx, " busy"}, 32'(busy), 32'(e.busy));
    chk({ctx, " done"}, 32'(done), 32'(e.done));
    if (e.idx_known) chk({ctx, " sym_idx"}, 32'(sym_idx), 32'(e.idx));
  endtask

  // Start at cycle 0 and follow the full timeline; with noise, inputs are
  // scrambled after capture and start is toggled while busy.
  task automatic play(input string name, input logic [63:0] a, input logic [63:0] b,
                      input int l, input bit noise);
    build(a, b, l);
    @(negedge clk);
    A = a; B = b; len = 6'(l); start = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      check_cycle($sformatf("%s c%0d", name, i + 1), q[i]);
      start = (noise && q[i].busy) ? 1'($urandom % 2) : 1'b0;
      if (noise) begin
        A   = {$urandom, $urandom};
        B   = {$urandom, $urandom};
        len = 6'($urandom);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; A = '0; B = '0; len = '0;
    repeat (2) @(negedge clk);
    check_cycle("reset", idle_e());
    rst = 1'b0;
    @(negedge clk);
    check_cycle("post_reset", idle_e());

    play("len3", 64'h0123_4567_89AB_CDEF, 64'h0, 3, 1'b0);
    play("len32", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 32, 1'b0);

    len = 6'd0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_cycle($sformatf("len0 c%0d", i + 1), idle_e());
    end
    start = 1'b0;

    play("len40", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 40, 1'b0);

    build(64'h0123_4567_89AB_CDEF, 64'h0, 3);
    @(negedge clk);
    A = 64'h0123_4567_89AB_CDEF; B = '0; len = 6'd3; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_cycle($sformatf("abort c%0d", i + 1), q[i]);
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    check_cycle("abort c7", idle_e());
    abort = 1'b0;
    @(negedge clk);
    check_cycle("abort c8", idle_e());
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check_cycle("abort_vs_start", idle_e());
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_cycle("abort_vs_start next", idle_e());
    play("after_abort", 64'h0123_4567_89AB_CDEF, 64'h0, 3, 1'b0);

    build(64'hA5A5_5A5A_1234_5678, 64'h0, 4);
    @(negedge clk);
    A = 64'hA5A5_5A5A_1234_5678; B = '0; len = 6'd4; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_cycle($sformatf("rst c%0d", i + 1), q[i]);
      start = 1'b0;
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check_cycle("rst c6", idle_e());
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_cycle("rst c7", idle_e());

    for (int r = 0; r < 12; r++) begin
      play($sformatf("rand%0d", r), {$urandom, $urandom}, {$urandom, $urandom},
           int'($urandom_range(1, 40)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
